// File: rtl/relu_dequant_serializer.sv
// ReLU dequantizer + beat serializer: latches a LANES-wide quantized vector and streams it
// as BEATS beats of expanded signed words. Optional macro RELU_DEQ_ROUND_EN adds midpoint reconstruction.

module relu_deq_lane #(
  parameter int IN_PRECISION  = 4,
  parameter int OUT_PRECISION = 18
) (
  input  logic [IN_PRECISION-1:0]  a,
  output logic [OUT_PRECISION-1:0] w
);
  always_comb begin
    w = {1'b0, a, {(OUT_PRECISION-1-IN_PRECISION){1'b0}}};
`ifdef RELU_DEQ_ROUND_EN
    // half-step bias for nonzero codes; zero must stay exactly zero
    w[OUT_PRECISION-2-IN_PRECISION] = |a;
`endif
  end
endmodule

module relu_dequant_serializer #(
  parameter int IN_PRECISION  = 4,
  parameter int OUT_PRECISION = 18,
  parameter int LANES         = 64,
  parameter int BEAT_LANES    = 16,
  localparam int BEATS        = LANES / BEAT_LANES,
  localparam int IDX_W        = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [IN_PRECISION*LANES-1:0]       act_in,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [OUT_PRECISION*BEAT_LANES-1:0] out_data,
  output logic [IDX_W-1:0]                    out_beat_idx,
  output logic                                out_last
);
  if (OUT_PRECISION < IN_PRECISION + 2) begin : g_bad_prec
    $error("relu_dequant_serializer: OUT_PRECISION must be >= IN_PRECISION+2");
  end
  if (LANES % BEAT_LANES != 0) begin : g_bad_lanes
    $error("relu_dequant_serializer: LANES must be a multiple of BEAT_LANES");
  end

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nxt;

  logic [BEATS-1:0][BEAT_LANES-1:0][IN_PRECISION-1:0] act_v, vec_q;
  logic [BEAT_LANES-1:0][IN_PRECISION-1:0]            beat_src;
  logic [BEAT_LANES-1:0][OUT_PRECISION-1:0]           beat_exp, data_q;
  logic [IDX_W-1:0] idx_q, idx_nxt;
  logic             last_q, accept, advance, load;

  assign act_v        = act_in;
  assign out_valid    = (state == SEND);
  assign out_last     = out_valid & last_q;
  assign in_ready     = (state == IDLE) | (out_last & out_ready);
  assign accept       = in_valid & in_ready;
  assign advance      = out_valid & out_ready & ~last_q;
  assign load         = accept | advance;
  assign out_data     = data_q;
  assign out_beat_idx = idx_q;

  // Next beat comes straight from act_in on acceptance so beat 0 is valid right after that edge.
  always_comb begin
    idx_nxt  = '0;
    beat_src = act_v[0];
    if (!accept) begin
      idx_nxt  = (idx_q == LAST_IDX) ? idx_q : idx_q + 1'b1;
      beat_src = vec_q[idx_nxt];
    end
  end

  for (genvar j = 0; j < BEAT_LANES; j++) begin : g_lane
    relu_deq_lane #(
      .IN_PRECISION (IN_PRECISION),
      .OUT_PRECISION(OUT_PRECISION)
    ) u_lane (
      .a(beat_src[j]),
      .w(beat_exp[j])
    );
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SEND;
      SEND:    if (out_ready && last_q && !in_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      vec_q  <= '0;
      data_q <= '0;
      idx_q  <= '0;
      last_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) vec_q <= act_v;
      if (load) begin
        data_q <= beat_exp;
        idx_q  <= idx_nxt;
        last_q <= (idx_nxt == LAST_IDX);
      end
    end
  end
endmodule

// File: tb/tb_relu_dequant_serializer.sv
// Directed bench for relu_dequant_serializer: expansion table, streaming, backpressure,
// back-to-back vectors and mid-vector reset.

module tb_relu_dequant_serializer;
  localparam int IN = 4, OUT = 18, LANES = 64, BL = 16, BEATS = 4;
  localparam int VW = IN * LANES, BW = OUT * BL;

  logic          clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [VW-1:0] act_in = '0;
  logic          in_ready, out_valid, out_last;
  logic [BW-1:0] out_data;
  logic [1:0]    out_beat_idx;

  relu_dequant_serializer #(
    .IN_PRECISION(IN), .OUT_PRECISION(OUT), .LANES(LANES), .BEAT_LANES(BL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .act_in(act_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_beat_idx(out_beat_idx), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  typedef struct {
    logic [IN-1:0]  a;
    logic [OUT-1:0] e;
  } vec_rec_t;
  vec_rec_t tbl [8];

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  function automatic logic [OUT-1:0] xp(input logic [IN-1:0] a);
    logic [OUT-1:0] w;
    w = {1'b0, a, 13'b0};
`ifdef RELU_DEQ_ROUND_EN
    if (a != 4'h0) w = w + 18'h01000;
`endif
    return w;
  endfunction

  function automatic logic [BW-1:0] beat(input logic [VW-1:0] v, input int b);
    logic [BW-1:0] r;
    r = '0;
    for (int j = 0; j < BL; j++) r[OUT*j +: OUT] = xp(v[IN*(b*BL+j) +: IN]);
    return r;
  endfunction

  function automatic logic [VW-1:0] rnd_vec();
    logic [VW-1:0] v;
    for (int k = 0; k < VW / 32; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [BW-1:0] q_data [$];
  logic [1:0]    q_idx [$];
  logic [VW-1:0] v, v_mod, bp_vecs [3], va, vb, vc, vd;
  logic [BW-1:0] held_data;
  logic [1:0]    held_idx;
  logic          stalled;
  int            nv, cyc;

  initial begin
`ifdef RELU_DEQ_ROUND_EN
    tbl = '{'{4'hA, 18'h15000}, '{4'hF, 18'h1F000}, '{4'h0, 18'h00000}, '{4'h1, 18'h03000},
            '{4'h5, 18'h0B000}, '{4'h8, 18'h11000}, '{4'h3, 18'h07000}, '{4'h7, 18'h0F000}};
`else
    tbl = '{'{4'hA, 18'h14000}, '{4'hF, 18'h1E000}, '{4'h0, 18'h00000}, '{4'h1, 18'h02000},
            '{4'h5, 18'h0A000}, '{4'h8, 18'h10000}, '{4'h3, 18'h06000}, '{4'h7, 18'h0E000}};
`endif
    for (int i = 0; i < LANES; i++) v_mod[IN*i +: IN] = 4'(i % 16);

    // reset
    #1 rst_n = 1'b0;
    #2;
    chk("rst_valid", BW'(out_valid), BW'(1'b0));
    chk("rst_data", out_data, '0);
    chk("rst_idx", BW'(out_beat_idx), '0);
    chk("rst_last", BW'(out_last), '0);
    #9 rst_n = 1'b1;
    #1 chk("rst_in_ready", BW'(in_ready), BW'(1'b1));

    // expansion table on beat 0, held by a stall
    v = v_mod;
    for (int k = 0; k < 8; k++) v[IN*k +: IN] = tbl[k].a;
    tick();
    act_in = v; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    #2;
    for (int k = 0; k < 8; k++)
      chk($sformatf("expand_lane%0d", k), BW'(out_data[OUT*k +: OUT]), BW'(tbl[k].e));
    chk("expand_idx", BW'(out_beat_idx), '0);
    tick(); #2;
    chk("stall_data", out_data, beat(v, 0));
    chk("stall_valid", BW'(out_valid), BW'(1'b1));
    out_ready = 1'b1;
    repeat (4) tick();
    #2 chk("drain_idle", BW'(out_valid), '0);

    // stream order
    tick();
    act_in = v_mod; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; act_in = '1;
    #2;
    for (int b = 0; b < BEATS; b++) begin
      chk($sformatf("stream_valid%0d", b), BW'(out_valid), BW'(1'b1));
      chk($sformatf("stream_idx%0d", b), BW'(out_beat_idx), BW'(b));
      chk($sformatf("stream_last%0d", b), BW'(out_last), BW'(b == 3));
      chk($sformatf("stream_in_ready%0d", b), BW'(in_ready), BW'(b == 3));
      chk($sformatf("stream_data%0d", b), out_data, beat(v_mod, b));
      tick(); #2;
    end
    chk("stream_end", BW'(out_valid), '0);

    // random backpressure against a scoreboard
    for (int k = 0; k < 3; k++) bp_vecs[k] = rnd_vec();
    nv = 0; stalled = 1'b0; cyc = 0;
    tick();
    while ((nv < 3 || q_data.size() != 0) && cyc < 600) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (nv < 3) && ($urandom_range(0, 3) != 0);
      act_in    = in_valid ? bp_vecs[nv] : rnd_vec();
      #2;
      if (stalled) begin
        chk("bp_hold_valid", BW'(out_valid), BW'(1'b1));
        chk("bp_hold_data", out_data, held_data);
        chk("bp_hold_idx", BW'(out_beat_idx), BW'(held_idx));
      end
      if (out_valid && out_ready) begin
        if (q_data.size() == 0) chk("bp_extra_beat", BW'(out_valid), '0);
        else begin
          chk("bp_data", out_data, q_data.pop_front());
          chk("bp_idx", BW'(out_beat_idx), BW'(q_idx.pop_front()));
        end
      end
      stalled = out_valid && !out_ready;
      held_data = out_data; held_idx = out_beat_idx;
      if (in_valid && in_ready) begin
        for (int b = 0; b < BEATS; b++) begin
          q_data.push_back(beat(bp_vecs[nv], b));
          q_idx.push_back(2'(b));
        end
        nv++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_drained", BW'(q_data.size()), '0);
    chk("bp_vectors", BW'(nv), BW'(3));
    #2 chk("bp_idle", BW'(out_valid), '0);

    // back-to-back vectors with in_valid held
    va = rnd_vec(); vb = rnd_vec();
    tick();
    act_in = va; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    act_in = vb;
    #2;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("b2b_valid%0d", k), BW'(out_valid), BW'(1'b1));
      chk($sformatf("b2b_idx%0d", k), BW'(out_beat_idx), BW'(k % 4));
      chk($sformatf("b2b_data%0d", k), out_data, beat((k < 4) ? va : vb, k % 4));
      if (k == 3) chk("b2b_in_ready", BW'(in_ready), BW'(1'b1));
      tick();
      if (k == 3) in_valid = 1'b0;
      #2;
    end
    chk("b2b_end", BW'(out_valid), '0);

    // reset in the middle of a vector
    vc = rnd_vec(); vd = rnd_vec();
    tick();
    act_in = vc; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); #2;
    chk("mid_idx1", BW'(out_beat_idx), BW'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", BW'(out_valid), '0);
    chk("mid_rst_data", out_data, '0);
    chk("mid_rst_idx", BW'(out_beat_idx), '0);
    chk("mid_rst_last", BW'(out_last), '0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); #2;
    chk("post_rst_no_beat", BW'(out_valid), '0);
    chk("post_rst_in_ready", BW'(in_ready), BW'(1'b1));
    tick();
    act_in = vd; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #2;
    chk("post_rst_valid", BW'(out_valid), BW'(1'b1));
    chk("post_rst_idx", BW'(out_beat_idx), '0);
    chk("post_rst_data", out_data, beat(vd, 0));
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
